// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp constants for the intersection scheduler.
// Provides per-road lamp decode helpers used by the top level.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      RED_A = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      RED_B = 3'd5
   } phase_e;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   function automatic logic [2:0] lamp_ns(input phase_e p);
      case (p)
         NS_G:    lamp_ns = LAMP_GRN;
         NS_Y:    lamp_ns = LAMP_YEL;
         default: lamp_ns = LAMP_RED;
      endcase
   endfunction

   function automatic logic [2:0] lamp_ew(input phase_e p);
      case (p)
         EW_G:    lamp_ew = LAMP_GRN;
         EW_Y:    lamp_ew = LAMP_YEL;
         default: lamp_ew = LAMP_RED;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// CW-bit loadable down-counter stepped by tick; hold freezes it.
// Ports: clk, rst_n, tick, hold, load, load_val in; cnt, expire out.
module phase_timer #(
   parameter int             CW      = 6,
   parameter logic [CW-1:0]  RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic          hold,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt,
   output logic          expire
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (tick && !hold && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= RST_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign cnt    = cnt_q;
   // Last tick of a phase; the owner must load the next duration.
   assign expire = tick & ~hold & (cnt_q == CW'(1));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// NS/EW intersection phase sequencer with NS green hold and walk latching.
// Ports: clk, rst_n, tick, veh_req_ew, ped_req_ns/ew, [emg_req] in;
// light_ns/ew, walk_ns/ew, phase, remain out.
// Optional emergency preempt: define EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int CW         = 6,
   parameter int T_GREEN_NS = 25,
   parameter int T_GREEN_EW = 25,
   parameter int T_YELLOW   = 5,
   parameter int T_ALL_RED  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic          veh_req_ew,
   input  logic          ped_req_ns,
   input  logic          ped_req_ew,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic          emg_req,
`endif
   output logic [2:0]    light_ns,
   output logic [2:0]    light_ew,
   output logic          walk_ns,
   output logic          walk_ew,
   output logic [2:0]    phase,
   output logic [CW-1:0] remain
);

   localparam logic [CW-1:0] TG_NS = CW'(T_GREEN_NS);
   localparam logic [CW-1:0] TG_EW = CW'(T_GREEN_EW);
   localparam logic [CW-1:0] TY    = CW'(T_YELLOW);
   localparam logic [CW-1:0] TAR   = CW'(T_ALL_RED);

   phase_e        phase_q, phase_d;
   logic [2:0]    light_ns_q, light_ew_q;
   logic          walk_ns_q, walk_ns_d;
   logic          walk_ew_q, walk_ew_d;
   logic          pend_ns_q, pend_ns_d;
   logic          pend_ew_q, pend_ew_d;
   logic          load, hold, expire;
   logic [CW-1:0] load_val;

   phase_timer #(
      .CW      (CW),
      .RST_VAL (TAR)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .hold     (hold),
      .load     (load),
      .load_val (load_val),
      .cnt      (remain),
      .expire   (expire)
   );

   always_comb begin
      phase_d   = phase_q;
      walk_ns_d = walk_ns_q;
      walk_ew_d = walk_ew_q;
      pend_ns_d = pend_ns_q | ped_req_ns;
      pend_ew_d = pend_ew_q | ped_req_ew;
      load      = 1'b0;
      load_val  = TAR;
      hold      = 1'b0;

      if (expire) begin
         load = 1'b1;
         case (phase_q)
            NS_G: begin
               // No EW demand: re-arm the NS green instead of cycling.
               if (veh_req_ew || pend_ew_q) begin
                  phase_d  = NS_Y;
                  load_val = TY;
               end else begin
                  load_val = TG_NS;
               end
            end
            NS_Y: begin
               phase_d  = RED_A;
               load_val = TAR;
            end
            RED_A: begin
               phase_d  = EW_G;
               load_val = TG_EW;
            end
            EW_G: begin
               phase_d  = EW_Y;
               load_val = TY;
            end
            EW_Y: begin
               phase_d  = RED_B;
               load_val = TAR;
            end
            default: begin
               phase_d  = NS_G;
               load_val = TG_NS;
            end
         endcase
      end

`ifdef EMERGENCY_PREEMPT_EN
      if (emg_req) begin
         if (phase_q == NS_G || phase_q == EW_G) begin
            phase_d  = (phase_q == NS_G) ? NS_Y : EW_Y;
            load     = 1'b1;
            load_val = TY;
         end else if (phase_q == RED_A || phase_q == RED_B) begin
            // Park the clearance at one tick left until release.
            hold     = 1'b1;
            phase_d  = phase_q;
            load     = (remain != CW'(1));
            load_val = CW'(1);
         end
      end
`endif

      // A request on the entry edge stays pending for the next green.
      if (phase_d == NS_G && phase_q != NS_G) begin
         walk_ns_d = pend_ns_q;
         pend_ns_d = ped_req_ns;
      end else if (phase_q == NS_G && phase_d != NS_G) begin
         walk_ns_d = 1'b0;
      end

      if (phase_d == EW_G && phase_q != EW_G) begin
         walk_ew_d = pend_ew_q;
         pend_ew_d = ped_req_ew;
      end else if (phase_q == EW_G && phase_d != EW_G) begin
         walk_ew_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= RED_B;
         light_ns_q <= LAMP_RED;
         light_ew_q <= LAMP_RED;
         walk_ns_q  <= 1'b0;
         walk_ew_q  <= 1'b0;
         pend_ns_q  <= 1'b0;
         pend_ew_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         light_ns_q <= lamp_ns(phase_d);
         light_ew_q <= lamp_ew(phase_d);
         walk_ns_q  <= walk_ns_d;
         walk_ew_q  <= walk_ew_d;
         pend_ns_q  <= pend_ns_d;
         pend_ew_q  <= pend_ew_d;
      end
   end

   assign phase    = phase_q;
   assign light_ns = light_ns_q;
   assign light_ew = light_ew_q;
   assign walk_ns  = walk_ns_q;
   assign walk_ew  = walk_ew_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: stimulus queues
// expected state per tick, monitor compares after each sampled edge.
module tb_traffic_phase_scheduler;

   localparam int PNS_G = 0, PNS_Y = 1, PRED_A = 2;
   localparam int PEW_G = 3, PEW_Y = 4, PRED_B = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       veh_req_ew = 1'b0;
   logic       ped_req_ns = 1'b0;
   logic       ped_req_ew = 1'b0;
   logic [2:0] light_ns, light_ew;
   logic       walk_ns, walk_ew;
   logic [2:0] phase;
   logic [5:0] remain;

   logic chk = 1'b0;
   logic snap = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      int         tid;
      logic [2:0] ph;
      logic [5:0] rem;
      logic [2:0] ln;
      logic [2:0] le;
      logic       wn;
      logic       we;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   traffic_phase_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .veh_req_ew (veh_req_ew),
      .ped_req_ns (ped_req_ns),
      .ped_req_ew (ped_req_ew),
`ifdef EMERGENCY_PREEMPT_EN
      .emg_req    (1'b0),
`endif
      .light_ns   (light_ns),
      .light_ew   (light_ew),
      .walk_ns    (walk_ns),
      .walk_ew    (walk_ew),
      .phase      (phase),
      .remain     (remain)
   );

   function automatic exp_t mk(input int tid, input int ph, input int rem,
                               input bit wn, input bit we);
      exp_t e;
      e.tid = tid;
      e.ph  = 3'(ph);
      e.rem = 6'(rem);
      e.ln  = (ph == PNS_G) ? 3'b001 : (ph == PNS_Y) ? 3'b010 : 3'b100;
      e.le  = (ph == PEW_G) ? 3'b001 : (ph == PEW_Y) ? 3'b010 : 3'b100;
      e.wn  = wn;
      e.we  = we;
      return e;
   endfunction

   task automatic compare();
      exp_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL underflow: output sampled with no expectation queued");
         return;
      end
      e = exp_q.pop_front();
      if (phase !== e.ph || remain !== e.rem || light_ns !== e.ln ||
          light_ew !== e.le || walk_ns !== e.wn || walk_ew !== e.we) begin
         n_fail++;
         $display("FAIL t%0d_ph%0d_rem%0d: got ph=%0d rem=%0d ns=%b ew=%b wn=%b we=%b, want ph=%0d rem=%0d ns=%b ew=%b wn=%b we=%b",
                  e.tid, e.ph, e.rem, phase, remain, light_ns, light_ew,
                  walk_ns, walk_ew, e.ph, e.rem, e.ln, e.le, e.wn, e.we);
      end
   endtask

   always @(posedge clk) begin
      if (chk) begin
         #1;
         compare();
      end
   end

   always @(posedge snap) begin
      #1;
      compare();
   end

   task automatic do_tick(input exp_t e, input bit idle);
      exp_q.push_back(e);
      tick = 1'b1;
      chk  = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk  = 1'b0;
      if (idle) @(negedge clk);
   endtask

   task automatic exp_run(input int tid, input int ph, input int hi,
                          input int lo, input bit wn, input bit we,
                          input bit burst);
      for (int r = hi; r >= lo; r--)
         do_tick(mk(tid, ph, r, wn, we), !burst);
   endtask

   task automatic check_idle(input exp_t e);
      exp_q.push_back(e);
      chk = 1'b1;
      @(negedge clk);
      chk = 1'b0;
   endtask

   task automatic check_snap(input exp_t e);
      exp_q.push_back(e);
      snap = 1'b1;
      #2;
      snap = 1'b0;
   endtask

   task automatic pulse(input bit ns);
      if (ns) ped_req_ns = 1'b1;
      else    ped_req_ew = 1'b1;
      @(negedge clk);
      ped_req_ns = 1'b0;
      ped_req_ew = 1'b0;
   endtask

   initial begin
      // Test 1: full cycle with EW demand held.
      repeat (2) @(negedge clk);
      #1;
      check_snap(mk(1, PRED_B, 2, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      veh_req_ew = 1'b1;
      check_idle(mk(1, PRED_B, 2, 0, 0));
      exp_run(1, PRED_B, 1, 1, 0, 0, 0);
      exp_run(1, PNS_G, 25, 1, 0, 0, 0);
      exp_run(1, PNS_Y, 5, 1, 0, 0, 0);
      exp_run(1, PRED_A, 2, 1, 0, 0, 0);
      exp_run(1, PEW_G, 25, 1, 0, 0, 1);
      exp_run(1, PEW_Y, 5, 1, 0, 0, 0);
      exp_run(1, PRED_B, 2, 1, 0, 0, 0);

      // Test 2: NS green holds without EW demand.
      veh_req_ew = 1'b0;
      exp_run(2, PNS_G, 25, 1, 0, 0, 0);
      exp_run(2, PNS_G, 25, 13, 0, 0, 1);
      veh_req_ew = 1'b1;
      exp_run(2, PNS_G, 12, 1, 0, 0, 0);
      exp_run(2, PNS_Y, 5, 1, 0, 0, 0);
      exp_run(2, PRED_A, 2, 1, 0, 0, 0);
      exp_run(2, PEW_G, 25, 1, 0, 0, 0);
      exp_run(2, PEW_Y, 5, 1, 0, 0, 0);
      exp_run(2, PRED_B, 2, 1, 0, 0, 0);

      // Test 3: EW ped request alone ends NS green and grants walk.
      veh_req_ew = 1'b0;
      exp_run(3, PNS_G, 25, 20, 0, 0, 0);
      pulse(1'b0);
      exp_run(3, PNS_G, 19, 1, 0, 0, 0);
      exp_run(3, PNS_Y, 5, 1, 0, 0, 0);
      exp_run(3, PRED_A, 2, 1, 0, 0, 0);
      exp_run(3, PEW_G, 25, 1, 0, 1, 0);
      exp_run(3, PEW_Y, 5, 1, 0, 0, 0);
      exp_run(3, PRED_B, 2, 1, 0, 0, 0);

      // Test 4: NS ped request on the green entry edge waits a cycle.
      veh_req_ew = 1'b1;
      ped_req_ns = 1'b1;
      do_tick(mk(4, PNS_G, 25, 0, 0), 1'b0);
      ped_req_ns = 1'b0;
      exp_run(4, PNS_G, 24, 1, 0, 0, 0);
      exp_run(4, PNS_Y, 5, 1, 0, 0, 0);
      exp_run(4, PRED_A, 2, 1, 0, 0, 0);
      exp_run(4, PEW_G, 25, 1, 0, 0, 0);
      exp_run(4, PEW_Y, 5, 1, 0, 0, 0);
      exp_run(4, PRED_B, 2, 1, 0, 0, 0);
      exp_run(4, PNS_G, 25, 1, 1, 0, 0);
      exp_run(4, PNS_Y, 5, 1, 0, 0, 0);
      exp_run(4, PRED_A, 2, 1, 0, 0, 0);

      // Test 5: async reset in EW green at remain 10 clears pending.
      exp_run(5, PEW_G, 25, 10, 0, 0, 0);
      pulse(1'b1);
      #2;
      rst_n = 1'b0;
      check_snap(mk(5, PRED_B, 2, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      check_idle(mk(5, PRED_B, 2, 0, 0));
      exp_run(5, PRED_B, 1, 1, 0, 0, 0);
      exp_run(5, PNS_G, 25, 20, 0, 0, 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         @(negedge clk);
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
